pid_mc: RTL and testbench

Time-multiplexed, parametrised PID core serving CHANNELS independent loops with one shared shift-add multiplier. On each start strobe it walks channels 0..CHANNELS-1. For each channel it fetches a process value over a ready/valid handshake, computes a saturated P+I+D stimulus with conditional-integration anti-windup, and emits it over a second handshake. It sits between the strobe generator, the SPI masters and the config register file in the controller top level.

---
 rtl/pid_mc.sv | 243 ++++++++++++++++++++++++
 tb/tb_pid_mc.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_mc.sv
// pid_mc: time-multiplexed PID core, CHANNELS loops sharing one shift-add multiplier.
// Latency: 3*KWIDTH+4 cycles per channel with zero-wait handshakes (REQ, ERR, 3 MUL phases, SAT, OUT).
// Backpressure: stalls in REQ until pv_valid; holds out_data/out_valid in OUT until out_ready.
module pid_mc #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int KWIDTH   = 4,
  parameter int SHIFT    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  start,
  input  logic                  cfg_we,
  input  logic [2:0]            cfg_ch,
  input  logic [WIDTH-1:0]      cfg_sp,
  input  logic [3*KWIDTH-1:0]   cfg_k,
  output logic                  pv_req,
  output logic [2:0]            pv_ch,
  input  logic                  pv_valid,
  input  logic [WIDTH-1:0]      pv_data,
  output logic                  out_valid,
  output logic [2:0]            out_ch,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  overrun
);

  localparam int CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int IW  = WIDTH + 4;
  localparam int IW1 = IW + 1;
  localparam int AW  = WIDTH + KWIDTH + 6;
  localparam int BW  = $clog2(KWIDTH + 1);
  localparam logic [CW-1:0]        LAST_CH = CW'(CHANNELS - 1);
  localparam logic [BW-1:0]        LAST_B  = BW'(KWIDTH - 1);
  localparam logic signed [IW:0]   IMAX    = IW1'((1 << (WIDTH + 3)) - 1);
  localparam logic signed [IW:0]   IMIN    = -IMAX;
  localparam logic signed [AW-1:0] YMAX    = AW'((1 << WIDTH) - 1);

  typedef enum logic [2:0] {IDLE, REQ, ERR, MUL_P, MUL_I, MUL_D, SAT, OUT} state_t;

  state_t                    state;
  logic [WIDTH-1:0]          sp_mem [CHANNELS];
  logic [3*KWIDTH-1:0]       k_mem  [CHANNELS];
  logic signed [IW-1:0]      integ  [CHANNELS];
  logic signed [WIDTH:0]     e_prev [CHANNELS];
  logic [CHANNELS-1:0]       sat_hi;
  logic [CHANNELS-1:0]       sat_lo;
  logic [CW-1:0]             ch;
  logic [BW-1:0]             bcnt;
  logic [WIDTH-1:0]          pv_r;
  logic [3*KWIDTH-1:0]       k_r;
  logic signed [WIDTH:0]     e_r;
  logic signed [WIDTH+1:0]   d_r;
  logic signed [IW-1:0]      i_r;
  logic signed [AW-1:0]      acc;

  logic signed [WIDTH:0]     e_c;
  logic signed [WIDTH+1:0]   d_c;
  logic signed [IW:0]        i_sum;
  logic signed [IW-1:0]      i_sat;
  logic signed [IW-1:0]      i_next;
  logic                      e_pos;
  logic                      e_neg;
  logic                      hold_i;
  logic signed [AW-1:0]      op;
  logic signed [AW-1:0]      term;
  logic [KWIDTH-1:0]         gain;
  logic                      kbit;
  logic signed [AW-1:0]      y;

  // Error, derivative and anti-windup integrator candidate for the active channel.
  always_comb begin
    e_c    = {1'b0, sp_mem[ch]} - {1'b0, pv_r};
    d_c    = {e_c[WIDTH], e_c} - {e_prev[ch][WIDTH], e_prev[ch]};
    i_sum  = {integ[ch][IW-1], integ[ch]} + {{(IW - WIDTH){e_c[WIDTH]}}, e_c};
    i_sat  = i_sum[IW-1:0];
    if (i_sum > IMAX) begin
      i_sat = IMAX[IW-1:0];
    end else if (i_sum < IMIN) begin
      i_sat = IMIN[IW-1:0];
    end
    e_pos  = !e_c[WIDTH] && (e_c != '0);
    e_neg  = e_c[WIDTH];
    // Conditional integration: freeze the integrator while pushing further into saturation.
    hold_i = (sat_hi[ch] && e_pos) || (sat_lo[ch] && e_neg);
    i_next = hold_i ? integ[ch] : i_sat;
  end

  // Operand/gain selection for the shared shift-add multiplier and the output scaling.
  always_comb begin
    case (state)
      MUL_I: begin
        op   = {{(AW - IW){i_r[IW-1]}}, i_r};
        gain = k_r[2*KWIDTH-1:KWIDTH];
      end
      MUL_D: begin
        op   = {{(AW - WIDTH - 2){d_r[WIDTH+1]}}, d_r};
        gain = k_r[3*KWIDTH-1:2*KWIDTH];
      end
      default: begin
        op   = {{(AW - WIDTH - 1){e_r[WIDTH]}}, e_r};
        gain = k_r[KWIDTH-1:0];
      end
    endcase
    kbit = |(gain & (KWIDTH'(1) << bcnt));
    term = op <<< bcnt;
    y    = acc >>> SHIFT;
  end

  // Per-channel setpoint and gain storage, writable at any time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        sp_mem[i] <= '0;
        k_mem[i]  <= '0;
      end
    end else if (cfg_we && (32'(cfg_ch) < CHANNELS)) begin
      sp_mem[cfg_ch[CW-1:0]] <= cfg_sp;
      k_mem[cfg_ch[CW-1:0]]  <= cfg_k;
    end
  end

  // Frame sequencer: fetch PV, compute, multiply, saturate and hand off each channel in turn.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ch        <= '0;
      bcnt      <= '0;
      pv_r      <= '0;
      k_r       <= '0;
      e_r       <= '0;
      d_r       <= '0;
      i_r       <= '0;
      acc       <= '0;
      sat_hi    <= '0;
      sat_lo    <= '0;
      pv_req    <= 1'b0;
      pv_ch     <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        integ[i]  <= '0;
        e_prev[i] <= '0;
      end
    end else begin
      if (start && busy) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start && enable) begin
            state  <= REQ;
            ch     <= '0;
            busy   <= 1'b1;
            pv_req <= 1'b1;
            pv_ch  <= '0;
          end
        end
        REQ: begin
          if (pv_valid) begin
            pv_r   <= pv_data;
            pv_req <= 1'b0;
            state  <= ERR;
          end
        end
        ERR: begin
          e_r           <= e_c;
          d_r           <= d_c;
          i_r           <= i_next;
          k_r           <= k_mem[ch];
          integ[ch]     <= i_next;
          e_prev[ch]    <= e_c;
          acc           <= '0;
          bcnt          <= '0;
          state         <= MUL_P;
        end
        MUL_P, MUL_I, MUL_D: begin
          if (kbit) begin
            acc <= acc + term;
          end
          if (bcnt == LAST_B) begin
            bcnt <= '0;
            case (state)
              MUL_P:   state <= MUL_I;
              MUL_I:   state <= MUL_D;
              default: state <= SAT;
            endcase
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        SAT: begin
          if (y[AW-1]) begin
            out_data   <= '0;
            sat_lo[ch] <= 1'b1;
            sat_hi[ch] <= 1'b0;
          end else if (y > YMAX) begin
            out_data   <= '1;
            sat_hi[ch] <= 1'b1;
            sat_lo[ch] <= 1'b0;
          end else begin
            out_data   <= y[WIDTH-1:0];
            sat_hi[ch] <= 1'b0;
            sat_lo[ch] <= 1'b0;
          end
          out_valid <= 1'b1;
          out_ch    <= 3'(ch);
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (ch == LAST_CH) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              ch     <= ch + 1'b1;
              pv_ch  <= 3'(ch + 1'b1);
              pv_req <= 1'b1;
              state  <= REQ;
            end
          end
        end
        default: state <= IDLE;
      endcase
      // Clear overrides any integrator/e_prev write made in the same cycle.
      if (clear) begin
        overrun <= 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
          integ[i]  <= '0;
          e_prev[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pid_mc.sv
// tb_pid_mc: directed frames against an integer-arithmetic PID model with per-acceptance checking.
// Expected stimuli are queued per frame; literal checks pin the model on the key test cases.
module tb_pid_mc;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        clear;
  logic        start;
  logic        cfg_we;
  logic [2:0]  cfg_ch;
  logic [7:0]  cfg_sp;
  logic [11:0] cfg_k;
  logic        pv_req;
  logic [2:0]  pv_ch;
  logic        pv_valid;
  logic [7:0]  pv_data;
  logic        out_valid;
  logic [2:0]  out_ch;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        busy;
  logic        overrun;

  int n_cmp = 0;
  int n_bad = 0;

  int m_sp[4], m_kp[4], m_ki[4], m_kd[4], m_i[4], m_ep[4];
  bit m_hi[4], m_lo[4];
  int exp_ch_q[$];
  int exp_dat_q[$];
  int got[4];
  bit hold_vld;
  int hold_dat;

  pid_mc #(.CHANNELS(4), .WIDTH(8), .KWIDTH(4), .SHIFT(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .start(start),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sp(cfg_sp), .cfg_k(cfg_k),
    .pv_req(pv_req), .pv_ch(pv_ch), .pv_valid(pv_valid), .pv_data(pv_data),
    .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_sp[c] = 0; m_kp[c] = 0; m_ki[c] = 0; m_kd[c] = 0;
      m_i[c] = 0; m_ep[c] = 0; m_hi[c] = 1'b0; m_lo[c] = 1'b0;
    end
  endtask

  // One frame of the PID law in plain integer arithmetic; queues the expected stimuli.
  task automatic model_frame(input int pvs[4]);
    for (int c = 0; c < 4; c++) begin
      int e, d, ii, acc, y, o;
      e = m_sp[c] - pvs[c];
      d = e - m_ep[c];
      if ((m_hi[c] && e > 0) || (m_lo[c] && e < 0)) begin
        ii = m_i[c];
      end else begin
        ii = m_i[c] + e;
        if (ii > 2047) ii = 2047;
        if (ii < -2047) ii = -2047;
      end
      acc = m_kp[c] * e + m_ki[c] * ii + m_kd[c] * d;
      y = acc >>> 2;
      if (y < 0) begin
        o = 0; m_lo[c] = 1'b1; m_hi[c] = 1'b0;
      end else if (y > 255) begin
        o = 255; m_hi[c] = 1'b1; m_lo[c] = 1'b0;
      end else begin
        o = y; m_hi[c] = 1'b0; m_lo[c] = 1'b0;
      end
      m_i[c] = ii;
      m_ep[c] = e;
      exp_ch_q.push_back(c);
      exp_dat_q.push_back(o);
    end
  endtask

  task automatic cfg(input int c, input int sp, input int kp, input int ki, input int kd);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_ch = 3'(c);
    cfg_sp = 8'(sp);
    cfg_k  = {4'(kd), 4'(ki), 4'(kp)};
    @(negedge clk);
    cfg_we = 1'b0;
    m_sp[c] = sp; m_kp[c] = kp; m_ki[c] = ki; m_kd[c] = kd;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    for (int c = 0; c < 4; c++) begin
      m_i[c] = 0;
      m_ep[c] = 0;
    end
  endtask

  // Runs one frame: serves PVs with zero wait, optionally stalls out_ready on one channel,
  // and at cycle poke_at pulses start and drops enable mid-frame.
  task automatic run_frame(input int p0, input int p1, input int p2, input int p3,
                           input int stall_ch, input int stall_n, input int poke_at,
                           input int exp_cycles);
    int pvs[4];
    int cyc;
    int stalled;
    pvs = '{p0, p1, p2, p3};
    model_frame(pvs);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    stalled = 0;
    while (busy && cyc < 300) begin
      start = (cyc == poke_at);
      if (cyc == poke_at) enable = 1'b0;
      pv_valid = pv_req;
      pv_data  = pv_req ? 8'(pvs[pv_ch[1:0]]) : 8'h00;
      if (out_valid && int'(out_ch) == stall_ch && stalled < stall_n) begin
        out_ready = 1'b0;
        stalled++;
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    pv_valid = 1'b0;
    out_ready = 1'b1;
    enable = 1'b1;
    chk("frame_done_busy", int'(busy), 0);
    chk("frame_cycles", cyc, exp_cycles);
    chk("frame_pending_outputs", exp_ch_q.size(), 0);
    exp_ch_q.delete();
    exp_dat_q.delete();
  endtask

  // Single compare process: checks each accepted stimulus and stability while stalled.
  always @(negedge clk) begin
    #1;
    if (reset) begin
      if (out_valid && hold_vld) chk("out_data_stable", int'(out_data), hold_dat);
      hold_vld = out_valid && !out_ready;
      hold_dat = int'(out_data);
      if (out_valid && out_ready) begin
        if (exp_ch_q.size() == 0) begin
          chk("out_unexpected_count", exp_ch_q.size(), 1);
        end else begin
          chk("out_ch", int'(out_ch), exp_ch_q.pop_front());
          chk("out_data", int'(out_data), exp_dat_q.pop_front());
          got[out_ch[1:0]] = int'(out_data);
        end
      end
    end else begin
      hold_vld = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; enable = 1'b1; clear = 1'b0; start = 1'b0;
    cfg_we = 1'b0; cfg_ch = 3'd0; cfg_sp = 8'd0; cfg_k = 12'd0;
    pv_valid = 1'b0; pv_data = 8'd0; out_ready = 1'b1;
    hold_vld = 1'b0; hold_dat = 0;
    for (int c = 0; c < 4; c++) got[c] = -1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_pv_req", int'(pv_req), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_pv_ch", int'(pv_ch), 0);
    chk("rst_out_ch", int'(out_ch), 0);
    reset = 1'b1;

    // Reset in the middle of MUL_I, then an all-zero-config frame.
    cfg(0, 100, 4, 0, 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("mid_pv_req", int'(pv_req), 1);
    pv_valid = 1'b1; pv_data = 8'd80;
    @(negedge clk); pv_valid = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_pv_req", int'(pv_req), 0);
    @(negedge clk); reset = 1'b1;
    model_reset();
    @(negedge clk);
    chk("post_rst_out_valid", int'(out_valid), 0);
    chk("post_rst_busy", int'(busy), 0);
    run_frame(0, 0, 0, 0, -1, 0, -1, 64);
    chk("zero_cfg_ch0", got[0], 0);
    chk("zero_cfg_ch3", got[3], 0);

    // P only on ch0 with a 3-cycle stall on ch1.
    cfg(0, 100, 4, 0, 0);
    run_frame(80, 0, 0, 0, 1, 3, -1, 67);
    chk("p_only_ch0", got[0], 20);

    // I only on ch1 over three frames, then clear.
    cfg(1, 100, 0, 2, 0);
    run_frame(80, 90, 0, 0, -1, 0, -1, 64);
    chk("i_frame1", got[1], 5);
    run_frame(80, 90, 0, 0, -1, 0, -1, 64);
    chk("i_frame2", got[1], 10);
    run_frame(80, 90, 0, 0, -1, 0, -1, 64);
    chk("i_frame3", got[1], 15);
    pulse_clear();
    run_frame(80, 90, 0, 0, -1, 0, -1, 64);
    chk("i_after_clear", got[1], 5);

    // D only on ch2.
    cfg(2, 100, 0, 0, 1);
    run_frame(80, 90, 80, 0, -1, 0, -1, 64);
    chk("d_frame1", got[2], 5);
    run_frame(80, 90, 80, 0, -1, 0, -1, 64);
    chk("d_frame2", got[2], 0);
    run_frame(80, 90, 100, 0, -1, 0, -1, 64);
    chk("d_frame3_neg", got[2], 0);

    // Saturation and anti-windup on ch3.
    cfg(3, 255, 15, 1, 0);
    run_frame(80, 90, 100, 0, -1, 0, -1, 64);
    chk("sat_frame1", got[3], 255);
    run_frame(80, 90, 100, 0, -1, 0, -1, 64);
    chk("sat_frame2", got[3], 255);
    cfg(3, 0, 0, 1, 0);
    run_frame(80, 90, 100, 0, -1, 0, -1, 64);
    chk("sat_integ_held", got[3], 63);
    cfg(3, 0, 1, 0, 0);
    run_frame(80, 90, 100, 200, -1, 0, -1, 64);
    chk("sat_low_clamp", got[3], 0);

    // Overrun and enable drop mid-frame; frame still completes, no extra frame.
    chk("overrun_before", int'(overrun), 0);
    run_frame(80, 90, 100, 200, -1, 0, 20, 64);
    chk("overrun_set", int'(overrun), 1);
    repeat (5) @(negedge clk);
    chk("no_extra_frame_busy", int'(busy), 0);
    chk("no_extra_frame_req", int'(pv_req), 0);
    pulse_clear();
    chk("overrun_cleared", int'(overrun), 0);

    // Start with enable low is ignored.
    enable = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    chk("disabled_pv_req", int'(pv_req), 0);
    chk("disabled_busy", int'(busy), 0);
    enable = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
